inport_reqgen: RTL and testbench

Input-channel controller for one router input port: buffers incoming flits, presents each packet's request (`req`, `port`, `multab`) to the five output-port mux controllers, and streams the packet out once granted. It is the requesting end of the mux-controller arbitration interface. One instance sits per input port, between the link receiver and the crossbar.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/inport_fifo.sv | 50 +++++
 rtl/inport_reqgen.sv | 156 +++++++++++++++
 tb/tb_inport_reqgen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type codes, input-channel FSM states and
// the port/status field widths used across the router.
package noc_pkg;

    localparam int PORT    = 4;
    localparam int PORTW   = 2;
    localparam int DSTATUS = 1;

    localparam logic [DSTATUS:0] MULTABS   = 2'b11;
    localparam logic [PORTW:0]   PORT_LAST = (PORTW+1)'(PORT);

    typedef enum logic [1:0] {
        BODY     = 2'b00,
        HEAD     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        SEND = 2'b10
    } state_t;

    function automatic logic is_header(input logic [1:0] t);
        return (t == HEAD) || (t == HEADTAIL);
    endfunction

endpackage

// File: rtl/inport_fifo.sv
// Circular buffer for the input channel; DEPTH must be a power of two so the
// pointers wrap on their own. Caller never writes when full or reads when empty.
module inport_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       i_wr_en,
    input  logic [W-1:0]               i_wr_data,
    input  logic                       i_rd_en,
    output logic [W-1:0]               o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_nonempty,
    output logic                       o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[r_wptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_en) r_wptr <= r_wptr + 1'b1;
            if (i_rd_en) r_rptr <= r_rptr + 1'b1;
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data  = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_nonempty = (r_count != '0);
    assign o_full     = (r_count == FULL_CNT);

endmodule

// File: rtl/inport_reqgen.sv
// Router input channel: buffers flits, requests the routed output port and
// streams the packet once granted. INPORT_STARVE_EN adds the starve flag.
module inport_reqgen
    import noc_pkg::*;
#(
    parameter int PORTID = 0,
    parameter int DEPTH  = 4,
    parameter int FLITW  = 32
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   in_valid,
    input  logic [FLITW-1:0]       in_flit,
    input  logic [1:0]             in_type,
    input  logic [PORTW:0]         in_port,
    input  logic [DSTATUS:0]       in_multab,
    output logic                   in_ready,
    output logic                   req,
    output logic [PORTW:0]         port,
    output logic [DSTATUS:0]       multab,
    input  logic [PORT:0]          grt,
    input  logic [PORT:0]          multab_ct,
    input  logic [PORT:0]          dn_ready,
    output logic                   out_valid,
    output logic [FLITW-1:0]       out_flit,
    output logic                   err_drop,
`ifdef INPORT_STARVE_EN
    output logic                   starve,
`endif
    output state_t                 dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count,
    output logic [PORTW:0]         dbg_portid
);
    // Upstream flit moves on in_valid & in_ready; a flit leaves on out_valid,
    // which already includes the grant, downstream ready and FIFO occupancy.
    localparam int EW = 2 + (PORTW+1) + (DSTATUS+1) + FLITW;

    logic [EW-1:0]            w_wr_data;
    logic [EW-1:0]            w_rd_data;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_nonempty;
    logic                     w_full;
    logic [1:0]               w_head_type;
    logic [PORTW:0]           w_head_port;
    logic [DSTATUS:0]         w_head_multab;
    logic [FLITW-1:0]         w_head_flit;

    state_t                   r_state;
    state_t                   w_next;
    logic [PORTW:0]           r_port;
    logic [DSTATUS:0]         r_multab;
    logic                     w_latch;
    logic                     w_drop;
    logic                     w_grt_sel;
    logic                     w_dn_sel;
    logic                     w_ct_ok;
    logic                     w_gsel;
    logic                     w_xfer;

    assign w_wr_data = {in_type, in_port, in_multab, in_flit};
    assign {w_head_type, w_head_port, w_head_multab, w_head_flit} = w_rd_data;

    inport_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk        (clk),
        .rst_       (rst_),
        .i_wr_en    (in_valid & ~w_full),
        .i_wr_data  (w_wr_data),
        .i_rd_en    (w_xfer | w_drop),
        .o_rd_data  (w_rd_data),
        .o_count    (w_count),
        .o_nonempty (w_nonempty),
        .o_full     (w_full)
    );

    // Port codes above the last output select nothing rather than wrapping.
    always_comb begin
        w_grt_sel = 1'b0;
        w_dn_sel  = 1'b0;
        if (r_port <= PORT_LAST) begin
            w_grt_sel = grt[r_port];
            w_dn_sel  = dn_ready[r_port];
        end
    end

    assign w_ct_ok = (r_multab != MULTABS) || (multab_ct == '0);
    assign w_gsel  = w_grt_sel & w_dn_sel & w_ct_ok;
    assign w_xfer  = (r_state != IDLE) & w_nonempty & w_gsel;

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_drop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_nonempty) begin
                    if (is_header(w_head_type)) begin
                        w_latch = 1'b1;
                        w_next  = WAIT;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (w_xfer) w_next = (w_head_type == HEADTAIL) ? IDLE : SEND;
            end
            SEND: begin
                if (w_xfer && (w_head_type == TAIL)) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state  <= IDLE;
            r_port   <= '0;
            r_multab <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_port   <= w_head_port;
                r_multab <= w_head_multab;
            end
        end
    end

`ifdef INPORT_STARVE_EN
    logic [7:0] r_starve_cnt;

    // Any cycle that leaves WAIT (or is not in it) restarts the count.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_starve_cnt <= '0;
        end else if ((r_state == WAIT) && (w_next == WAIT)) begin
            if (!w_xfer && (r_starve_cnt != 8'hFF)) r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign starve = r_starve_cnt[7];
`endif

    assign in_ready   = ~w_full;
    assign req        = (r_state != IDLE);
    assign port       = r_port;
    assign multab     = r_multab;
    assign out_valid  = w_xfer;
    assign out_flit   = w_head_flit;
    assign err_drop   = w_drop;
    assign dbg_state  = r_state;
    assign dbg_count  = w_count;
    assign dbg_portid = (PORTW+1)'(PORTID);

endmodule

// File: tb/tb_inport_reqgen.sv
// Bench for inport_reqgen: directed scenarios plus a randomized run checked
// against a packet-level queue model.
module tb_inport_reqgen;
  import noc_pkg::*;

  localparam int DEPTH = 4;
  localparam int FLITW = 32;

  logic clk = 1'b0;
  logic rst_;
  logic in_valid;
  logic [FLITW-1:0] in_flit;
  logic [1:0] in_type;
  logic [PORTW:0] in_port;
  logic [DSTATUS:0] in_multab;
  logic in_ready;
  logic req;
  logic [PORTW:0] port;
  logic [DSTATUS:0] multab;
  logic [PORT:0] grt;
  logic [PORT:0] multab_ct;
  logic [PORT:0] dn_ready;
  logic out_valid;
  logic [FLITW-1:0] out_flit;
  logic err_drop;
`ifdef INPORT_STARVE_EN
  logic starve;
`endif
  state_t dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;
  logic [PORTW:0] dbg_portid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] typ;
    logic [PORTW:0] prt;
    logic [DSTATUS:0] mt;
    logic [FLITW-1:0] flit;
  } ent_t;

  ent_t mq[$];
  ent_t stream[$];
  logic m_req;
  logic [PORTW:0] m_port;
  logic [DSTATUS:0] m_mt;

  always #5 clk = ~clk;

  inport_reqgen #(.PORTID(0), .DEPTH(DEPTH), .FLITW(FLITW)) dut (
    .clk(clk), .rst_(rst_),
    .in_valid(in_valid), .in_flit(in_flit), .in_type(in_type),
    .in_port(in_port), .in_multab(in_multab), .in_ready(in_ready),
    .req(req), .port(port), .multab(multab),
    .grt(grt), .multab_ct(multab_ct), .dn_ready(dn_ready),
    .out_valid(out_valid), .out_flit(out_flit), .err_drop(err_drop),
`ifdef INPORT_STARVE_EN
    .starve(starve),
`endif
    .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_portid(dbg_portid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_flit = '0;
    in_type = BODY;
    in_port = '0;
    in_multab = '0;
    grt = '0;
    multab_ct = '0;
    dn_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ = 1'b0;
    tick();
    tick();
    rst_ = 1'b1;
    mq.delete();
    stream.delete();
    m_req = 1'b0;
    m_port = '0;
    m_mt = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", req); end
    n_vec++; if (port !== '0) begin n_err++; $display("FAIL reset_port: got %0d want 0", port); end
    n_vec++; if (multab !== '0) begin n_err++; $display("FAIL reset_multab: got %0d want 0", multab); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL reset_err_drop: got %b want 0", err_drop); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    n_vec++; if (dbg_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
    n_vec++; if (dbg_portid !== '0) begin n_err++; $display("FAIL reset_portid: got %0d want 0", dbg_portid); end
  endtask

  task automatic test_headtail();
    logic [FLITW-1:0] f;
    do_reset();
    f = $urandom;
    grt = 5'b00100;
    dn_ready = 5'b11111;
    in_valid = 1'b1; in_type = HEADTAIL; in_port = 3'd2; in_multab = '0; in_flit = f;
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL ht_req_early: got %b want 0", req); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ht_valid_early: got %b want 0", out_valid); end
    tick();
    #1;
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL ht_req: got %b want 1", req); end
    n_vec++; if (port !== 3'd2) begin n_err++; $display("FAIL ht_port: got %0d want 2", port); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ht_valid: got %b want 1", out_valid); end
    n_vec++; if (out_flit !== f) begin n_err++; $display("FAIL ht_flit: got %h want %h", out_flit, f); end
    tick();
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL ht_req_after: got %b want 0", req); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ht_valid_after: got %b want 0", out_valid); end
    n_vec++; if (dbg_count !== '0) begin n_err++; $display("FAIL ht_count_after: got %0d want 0", dbg_count); end
  endtask

  task automatic test_packet_stall();
    logic [FLITW-1:0] f[4];
    logic [1:0] types[4];
    int k;
    logic stall;
    do_reset();
    types = '{HEAD, BODY, BODY, TAIL};
    grt = 5'b01000;
    dn_ready = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      f[i] = $urandom;
      in_valid = 1'b1; in_type = types[i]; in_flit = f[i];
      in_port = (i == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      in_multab = (i == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_vec++; if (dbg_count !== 3'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", dbg_count); end
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL pkt_req_wait: got %b want 1", req); end
    k = 0;
    for (int c = 0; c < 7; c++) begin
      stall = (c >= 2) && (c < 5);
      dn_ready = stall ? 5'b10111 : 5'b11111;
      #1;
      if (c == 1) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready_after: got %b want 1", in_ready); end
        n_vec++; if (dbg_count !== 3'd3) begin n_err++; $display("FAIL full_count_after: got %0d want 3", dbg_count); end
      end
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL pkt_req_c%0d: got %b want 1", c, req); end
      if (stall) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pkt_stall_c%0d: got %b want 0", c, out_valid); end
      end else begin
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pkt_valid_c%0d: got %b want 1", c, out_valid); end
        n_vec++; if (out_flit !== f[k]) begin n_err++; $display("FAIL pkt_flit%0d: got %h want %h", k, out_flit, f[k]); end
        k++;
      end
      tick();
    end
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL pkt_req_end: got %b want 0", req); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL pkt_state_end: got %0d want IDLE", dbg_state); end
    n_vec++; if (dbg_count !== '0) begin n_err++; $display("FAIL pkt_count_end: got %0d want 0", dbg_count); end
  endtask

  task automatic test_orphan();
    logic [1:0] t;
    do_reset();
    grt = 5'b11111;
    dn_ready = 5'b11111;
    for (int i = 0; i < 2; i++) begin
      t = (i == 0) ? BODY : TAIL;
      in_valid = 1'b1; in_type = t; in_port = 3'd1; in_flit = $urandom;
      tick();
      in_valid = 1'b0;
      #1;
      n_vec++; if (err_drop !== 1'b1) begin n_err++; $display("FAIL orphan%0d_drop: got %b want 1", i, err_drop); end
      n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL orphan%0d_req: got %b want 0", i, req); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL orphan%0d_valid: got %b want 0", i, out_valid); end
      tick();
      #1;
      n_vec++; if (err_drop !== 1'b0) begin n_err++; $display("FAIL orphan%0d_drop_after: got %b want 0", i, err_drop); end
      n_vec++; if (dbg_count !== '0) begin n_err++; $display("FAIL orphan%0d_count: got %0d want 0", i, dbg_count); end
      n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL orphan%0d_req_after: got %b want 0", i, req); end
    end
  endtask

  task automatic test_multab_contention();
    logic [FLITW-1:0] f;
    do_reset();
    f = $urandom;
    grt = 5'b00010;
    dn_ready = 5'b11111;
    multab_ct = 5'b00010;
    in_valid = 1'b1; in_type = HEADTAIL; in_port = 3'd1; in_multab = MULTABS; in_flit = f;
    tick();
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL mt_req_c%0d: got %b want 1", c, req); end
      n_vec++; if (multab !== MULTABS) begin n_err++; $display("FAIL mt_multab_c%0d: got %0d want %0d", c, multab, MULTABS); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mt_blocked_c%0d: got %b want 0", c, out_valid); end
      tick();
    end
    multab_ct = '0;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mt_valid: got %b want 1", out_valid); end
    n_vec++; if (out_flit !== f) begin n_err++; $display("FAIL mt_flit: got %h want %h", out_flit, f); end
    tick();
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL mt_req_after: got %b want 0", req); end
  endtask

  task automatic gen_packet();
    ent_t e;
    int len;
    logic [PORTW:0] p;
    logic [DSTATUS:0] mt;
    if ($urandom_range(0, 9) == 0) begin
      e.typ = ($urandom_range(0, 1) == 0) ? BODY : TAIL;
      e.prt = 3'($urandom_range(0, 7));
      e.mt = 2'($urandom_range(0, 3));
      e.flit = $urandom;
      stream.push_back(e);
    end else begin
      len = $urandom_range(1, 5);
      p = 3'($urandom_range(0, 4));
      mt = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        if (len == 1) e.typ = HEADTAIL;
        else if (i == 0) e.typ = HEAD;
        else if (i == len - 1) e.typ = TAIL;
        else e.typ = BODY;
        e.prt = (i == 0) ? p : 3'($urandom_range(0, 7));
        e.mt = (i == 0) ? mt : 2'($urandom_range(0, 3));
        e.flit = $urandom;
        stream.push_back(e);
      end
    end
  endtask

  task automatic test_random(input int ncyc);
    ent_t h;
    logic hv, e_ready, gsel, e_xfer, e_drop, start;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (stream.size() == 0) gen_packet();
      in_valid = ($urandom_range(0, 3) != 0);
      in_type = stream[0].typ; in_port = stream[0].prt;
      in_multab = stream[0].mt; in_flit = stream[0].flit;
      grt = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
      dn_ready = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
      multab_ct = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      #1;
      hv = (mq.size() > 0);
      if (hv) h = mq[0];
      e_ready = (mq.size() != DEPTH);
      gsel = grt[m_port] && dn_ready[m_port] && ((m_mt != MULTABS) || (multab_ct == 5'd0));
      e_xfer = m_req && hv && gsel;
      e_drop = !m_req && hv && ((h.typ == BODY) || (h.typ == TAIL));
      start = !m_req && hv && ((h.typ == HEAD) || (h.typ == HEADTAIL));
      n_vec++; if (in_ready !== e_ready) begin n_err++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, e_ready); end
      n_vec++; if (req !== m_req) begin n_err++; $display("FAIL rnd_req c%0d: got %b want %b", c, req, m_req); end
      n_vec++; if (port !== m_port) begin n_err++; $display("FAIL rnd_port c%0d: got %0d want %0d", c, port, m_port); end
      n_vec++; if (multab !== m_mt) begin n_err++; $display("FAIL rnd_multab c%0d: got %0d want %0d", c, multab, m_mt); end
      n_vec++; if (out_valid !== e_xfer) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, e_xfer); end
      n_vec++; if (err_drop !== e_drop) begin n_err++; $display("FAIL rnd_err_drop c%0d: got %b want %b", c, err_drop, e_drop); end
      if (e_xfer) begin
        n_vec++; if (out_flit !== h.flit) begin n_err++; $display("FAIL rnd_out_flit c%0d: got %h want %h", c, out_flit, h.flit); end
      end
      if (e_xfer || e_drop) void'(mq.pop_front());
      if (e_xfer && ((h.typ == TAIL) || (h.typ == HEADTAIL))) m_req = 1'b0;
      if (start) begin
        m_req = 1'b1;
        m_port = h.prt;
        m_mt = h.mt;
      end
      if (in_valid && e_ready) mq.push_back(stream.pop_front());
      tick();
    end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    grt = 5'b10000;
    dn_ready = 5'b00000;
    in_valid = 1'b1; in_type = HEAD; in_port = 3'd4; in_multab = '0; in_flit = $urandom;
    tick();
    in_type = BODY; in_flit = $urandom;
    tick();
    in_valid = 1'b0;
    dn_ready = 5'b11111;
    tick();
    dn_ready = 5'b00000;
    #1;
    n_vec++; if (dbg_state !== SEND) begin n_err++; $display("FAIL rst_pre_state: got %0d want SEND", dbg_state); end
    n_vec++; if (port !== 3'd4) begin n_err++; $display("FAIL rst_pre_port: got %0d want 4", port); end
    dn_ready = 5'b11111;
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
    #1;
    rst_ = 1'b0;
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", req); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (port !== '0) begin n_err++; $display("FAIL rst_port: got %0d want 0", port); end
    n_vec++; if (dbg_count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", dbg_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst_ = 1'b1;
    tick();
    #1;
    n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL rst_req_after: got %b want 0", req); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state_after: got %0d want IDLE", dbg_state); end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_packet_stall();
    test_orphan();
    test_multab_contention();
    test_random(800);
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
